video_mode_ctrl: RTL and testbench

Sequences video-mode changes (NTSC/PAL, scandouble) into the `atari_wcc` video core so that a switch never takes effect mid-frame. It sits between the hps_io status bits and the core's `pal`/`scandouble` inputs. It defers each request to a VSync boundary, then pulses the core reset, then blanks output for a settle period before handing back to normal running. It also merges the user/OSD reset into the core reset.

---
 rtl/video_mode_ctrl.sv | 148 ++++++++++++++
 tb/tb_video_mode_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl
// Sequences PAL/NTSC and scandouble changes into the video core. A request is
// held until the next VSync rising edge (or a watchdog expiry), the core is
// then held in reset for RST_CYCLES clocks, and the output stays blanked for
// SETTLE_FRAMES further VSync edges before normal running resumes. The
// OSD/button reset is merged into the core reset without touching the sequencer.

module video_mode_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_FRAMES = 2,
  parameter int TIMEOUT_BITS  = 22
) (
  input  logic clk,
  input  logic reset,
  input  logic req_pal,
  input  logic req_scandouble,
  input  logic user_reset,
  input  logic VSync,
  output logic core_pal,
  output logic core_scandouble,
  output logic core_reset,
  output logic force_blank,
  output logic busy,
  output logic mode_changed
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int FW = $clog2(SETTLE_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_VB,
    ST_RESET,
    ST_SETTLE
  } state_t;

  state_t                    state, next_state;
  logic                      vs_d;
  logic                      vs_edge;
  logic [1:0]                req_pair;
  logic [1:0]                applied;
  logic [1:0]                lat_pair, next_lat_pair;
  logic                      next_core_pal, next_core_scandouble;
  logic                      next_mode_changed;
  logic [TIMEOUT_BITS-1:0]   wd_cnt, next_wd_cnt;
  logic [RW-1:0]             rst_cnt, next_rst_cnt;
  logic [FW-1:0]             frame_cnt, next_frame_cnt;

  assign vs_edge  = VSync & ~vs_d;
  assign req_pair = {req_pal, req_scandouble};
  assign applied  = {core_pal, core_scandouble};

  // State register plus all sequencer datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and the order of statements does not matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_RUN;
      vs_d            <= 1'b1;
      core_pal        <= 1'b0;
      core_scandouble <= 1'b0;
      lat_pair        <= 2'b00;
      wd_cnt          <= '0;
      rst_cnt         <= '0;
      frame_cnt       <= '0;
      mode_changed    <= 1'b0;
    end else begin
      state           <= next_state;
      vs_d            <= VSync;
      core_pal        <= next_core_pal;
      core_scandouble <= next_core_scandouble;
      lat_pair        <= next_lat_pair;
      wd_cnt          <= next_wd_cnt;
      rst_cnt         <= next_rst_cnt;
      frame_cnt       <= next_frame_cnt;
      mode_changed    <= next_mode_changed;
    end
  end

  // Next-state and next-datapath decode for the mode-change sequence.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state           = state;
    next_core_pal        = core_pal;
    next_core_scandouble = core_scandouble;
    next_lat_pair        = lat_pair;
    next_wd_cnt          = wd_cnt;
    next_rst_cnt         = rst_cnt;
    next_frame_cnt       = frame_cnt;
    next_mode_changed    = 1'b0;

    unique case (state)
      ST_RUN: begin
        if (req_pair != applied) begin
          next_lat_pair = req_pair;
          next_wd_cnt   = '0;
          next_state    = ST_WAIT_VB;
        end
      end

      ST_WAIT_VB: begin
        // Latest request wins; a request that reverts cancels the switch.
        next_lat_pair = req_pair;
        next_wd_cnt   = wd_cnt + TIMEOUT_BITS'(1);
        if (req_pair == applied) begin
          next_state = ST_RUN;
        end else if (vs_edge || (&wd_cnt)) begin
          {next_core_pal, next_core_scandouble} = lat_pair;
          next_rst_cnt = RW'(RST_CYCLES);
          next_state   = ST_RESET;
        end
      end

      ST_RESET: begin
        if (rst_cnt == RW'(1)) begin
          next_rst_cnt   = '0;
          next_frame_cnt = FW'(SETTLE_FRAMES);
          next_state     = ST_SETTLE;
        end else begin
          next_rst_cnt = rst_cnt - RW'(1);
        end
      end

      ST_SETTLE: begin
        if (vs_edge) begin
          if (frame_cnt == FW'(1)) begin
            next_frame_cnt    = '0;
            next_mode_changed = 1'b1;
            next_state        = ST_RUN;
          end else begin
            next_frame_cnt = frame_cnt - FW'(1);
          end
        end
      end

      default: next_state = ST_RUN;
    endcase
  end

  // Outputs decoded from the registered state; user reset bypasses the FSM.
  always_comb begin
    core_reset  = (state == ST_RESET) | user_reset;
    force_blank = (state == ST_RESET) || (state == ST_SETTLE);
    busy        = (state != ST_RUN);
  end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb_video_mode_ctrl
// Directed bench for video_mode_ctrl with RST_CYCLES=4, SETTLE_FRAMES=2,
// TIMEOUT_BITS=8. Inputs change 1 ns after a rising edge; outputs are
// observed at that same point, well clear of the next edge.

module tb_video_mode_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic req_pal, req_scandouble, user_reset, VSync;
  logic core_pal, core_scandouble, core_reset, force_blank, busy, mode_changed;

  int n_checks = 0;
  int n_pass   = 0;
  int rst_hi, mc_cnt;

  video_mode_ctrl #(
    .RST_CYCLES   (4),
    .SETTLE_FRAMES(2),
    .TIMEOUT_BITS (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_pal        (req_pal),
    .req_scandouble (req_scandouble),
    .user_reset     (user_reset),
    .VSync          (VSync),
    .core_pal       (core_pal),
    .core_scandouble(core_scandouble),
    .core_reset     (core_reset),
    .force_blank    (force_blank),
    .busy           (busy),
    .mode_changed   (mode_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a sequence to completion with VSync high 3 of every 100 cycles,
  // counting core_reset-high cycles and mode_changed pulses on the way.
  task automatic seq_run(input int max_cyc, output int rst_cycles, output int mc_pulses);
    logic done = 1'b0;
    rst_cycles = 0;
    mc_pulses  = 0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      VSync = ((i % 100) >= 97);
      tick();
      if (core_reset)   rst_cycles++;
      if (mode_changed) mc_pulses++;
      if (!busy)        done = 1'b1;
    end
    VSync = 1'b0;
    check("seq_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    req_pal = 1'b0; req_scandouble = 1'b0; user_reset = 1'b0; VSync = 1'b0;
    repeat (3) tick();
    check("rst_pal",   {31'd0, core_pal},        32'd0);
    check("rst_sd",    {31'd0, core_scandouble}, 32'd0);
    check("rst_creset",{31'd0, core_reset},      32'd0);
    check("rst_blank", {31'd0, force_blank},     32'd0);
    check("rst_busy",  {31'd0, busy},            32'd0);
    check("rst_mc",    {31'd0, mode_changed},    32'd0);

    // ---- Test 1: request 10 at reset release, full sequence ----
    req_pal = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_pal_wait", {31'd0, core_pal}, 32'd0);
    repeat (5) tick();
    VSync = 1'b1;
    tick();
    check("t1_pal_applied", {31'd0, core_pal}, 32'd1);
    check("t1_creset_v1", {31'd0, core_reset}, 32'd1);
    check("t1_blank_v1", {31'd0, force_blank}, 32'd1);
    VSync = 1'b0;
    tick();
    check("t1_creset_v2", {31'd0, core_reset}, 32'd1);
    VSync = 1'b1;              // rising edge while in RESET: must not count
    tick();
    check("t1_creset_v3", {31'd0, core_reset}, 32'd1);
    tick();
    check("t1_creset_v4", {31'd0, core_reset}, 32'd1);
    VSync = 1'b0;
    tick();
    check("t1_creset_end", {31'd0, core_reset}, 32'd0);
    check("t1_blank_settle", {31'd0, force_blank}, 32'd1);
    repeat (10) tick();
    VSync = 1'b1;
    tick();
    check("t1_mc_early", {31'd0, mode_changed}, 32'd0);
    check("t1_blank_f1", {31'd0, force_blank}, 32'd1);
    repeat (2) tick();
    VSync = 1'b0;
    repeat (10) tick();
    VSync = 1'b1;
    tick();
    check("t1_mc_pulse", {31'd0, mode_changed}, 32'd1);
    check("t1_blank_off", {31'd0, force_blank}, 32'd0);
    check("t1_busy_off", {31'd0, busy}, 32'd0);
    check("t1_pair", {30'd0, core_pal, core_scandouble}, 32'h2);
    tick();
    check("t1_mc_clear", {31'd0, mode_changed}, 32'd0);
    tick();
    VSync = 1'b0;
    tick();

    // ---- Test 2a: 10 -> 11 -> 01 in WAIT_VB, one reset pulse ----
    req_scandouble = 1'b1;
    tick();
    check("t2_busy", {31'd0, busy}, 32'd1);
    req_pal = 1'b0;
    repeat (3) tick();
    check("t2_still_wait", {31'd0, force_blank}, 32'd0);
    seq_run(1000, rst_hi, mc_cnt);
    check("t2_rst_cycles", rst_hi, 32'd4);
    check("t2_mc_count", mc_cnt, 32'd1);
    check("t2_pair", {30'd0, core_pal, core_scandouble}, 32'h1);
    tick();
    check("t2_mc_clear", {31'd0, mode_changed}, 32'd0);

    // ---- Test 2b: 00 -> 10 -> 00 cancels without reset ----
    reset = 1'b1;
    req_pal = 1'b0; req_scandouble = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    req_pal = 1'b1;
    tick();
    check("t2b_busy", {31'd0, busy}, 32'd1);
    req_pal = 1'b0;
    tick();
    check("t2b_cancel", {31'd0, busy}, 32'd0);
    check("t2b_mc", {31'd0, mode_changed}, 32'd0);
    VSync = 1'b1;
    tick();
    check("t2b_no_reset", {31'd0, core_reset}, 32'd0);
    check("t2b_pair", {30'd0, core_pal, core_scandouble}, 32'h0);
    VSync = 1'b0;
    tick();

    // ---- Test 3: requests during RESET/SETTLE wait for RUN ----
    req_pal = 1'b1;
    tick();
    VSync = 1'b1;
    tick();
    check("t3_pal", {31'd0, core_pal}, 32'd1);
    repeat (2) tick();
    VSync = 1'b0;
    req_pal = 1'b0; req_scandouble = 1'b1;
    repeat (5) tick();
    check("t3_ignored", {30'd0, core_pal, core_scandouble}, 32'h2);
    check("t3_blank", {31'd0, force_blank}, 32'd1);
    VSync = 1'b1;
    tick();
    check("t3_busy_f1", {31'd0, busy}, 32'd1);
    req_pal = 1'b1;
    repeat (2) tick();
    VSync = 1'b0;
    repeat (10) tick();
    check("t3_ignored2", {30'd0, core_pal, core_scandouble}, 32'h2);
    VSync = 1'b1;
    tick();
    check("t3_mc", {31'd0, mode_changed}, 32'd1);
    check("t3_busy_off", {31'd0, busy}, 32'd0);
    tick();
    check("t3_back2back", {31'd0, busy}, 32'd1);
    check("t3_mc_clear", {31'd0, mode_changed}, 32'd0);
    seq_run(1000, rst_hi, mc_cnt);
    check("t3_rst_cycles", rst_hi, 32'd4);
    check("t3_mc_count", mc_cnt, 32'd1);
    check("t3_pair", {30'd0, core_pal, core_scandouble}, 32'h3);
    tick();

    // ---- Test 6a: user reset in RUN only drives core_reset ----
    user_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_ureset", {31'd0, core_reset}, 32'd1);
      check("t6_busy", {31'd0, busy}, 32'd0);
      tick();
    end
    user_reset = 1'b0;
    #1;
    check("t6_ureset_off", {31'd0, core_reset}, 32'd0);
    check("t6_pair", {30'd0, core_pal, core_scandouble}, 32'h3);
    check("t6_blank", {31'd0, force_blank}, 32'd0);
    tick();

    // ---- Test 4: watchdog expiry with VSync held low ----
    req_pal = 1'b0; req_scandouble = 1'b0;
    tick();
    repeat (255) tick();
    check("t4_wait_blank", {31'd0, force_blank}, 32'd0);
    check("t4_wait_busy", {31'd0, busy}, 32'd1);
    check("t4_wait_pair", {30'd0, core_pal, core_scandouble}, 32'h3);
    tick();
    check("t4_pair", {30'd0, core_pal, core_scandouble}, 32'h0);
    check("t4_creset", {31'd0, core_reset}, 32'd1);
    repeat (3) tick();
    check("t4_creset_last", {31'd0, core_reset}, 32'd1);
    tick();
    check("t4_creset_end", {31'd0, core_reset}, 32'd0);
    repeat (300) tick();
    check("t4_blank_hold", {31'd0, force_blank}, 32'd1);
    check("t4_busy_hold", {31'd0, busy}, 32'd1);
    seq_run(1000, rst_hi, mc_cnt);
    check("t4_rst_cycles", rst_hi, 32'd0);
    check("t4_mc_count", mc_cnt, 32'd1);
    tick();

    // ---- Test 5: VSync high through reset release is not an edge ----
    req_pal = 1'b1;
    VSync = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("t5_busy", {31'd0, busy}, 32'd1);
    repeat (3) tick();
    check("t5_no_edge_blank", {31'd0, force_blank}, 32'd0);
    check("t5_no_edge_pal", {31'd0, core_pal}, 32'd0);
    VSync = 1'b0;
    tick();
    VSync = 1'b1;
    tick();
    check("t5_edge_pal", {31'd0, core_pal}, 32'd1);
    check("t5_edge_creset", {31'd0, core_reset}, 32'd1);

    // ---- Test 6b: async reset while in RESET ----
    #2;
    reset = 1'b1;
    #1;
    check("t6b_pal", {31'd0, core_pal}, 32'd0);
    check("t6b_creset", {31'd0, core_reset}, 32'd0);
    check("t6b_blank", {31'd0, force_blank}, 32'd0);
    check("t6b_busy", {31'd0, busy}, 32'd0);
    check("t6b_mc", {31'd0, mode_changed}, 32'd0);
    req_pal = 1'b0;
    VSync = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("t6b_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
